// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit port between NREQ byte producers, with an optional per-owner lock.
// Latency: req seen in IDLE at edge k -> uart_we high after k+1 (port not full), ack after k+1+STROBE_CYC.
// Backpressure: uart_busy holds the byte in WAIT indefinitely; once strobing, uart_busy is ignored.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req[NREQ]       level byte request per requester
//   lock[NREQ]      owner keeps the grant across bytes while high
//   data[8*NREQ]    byte per requester, requester i at [8i+7:8i]
//   ack[NREQ]       one-cycle pulse when the owner's byte has been strobed
//   grant[NREQ]     one-hot current owner, 0 when none
//   uart_data[8]    byte to the port
//   uart_we         write strobe to the port (edge-detected there)
//   uart_busy       port FIFO full
module uart_tx_arbiter #(
    parameter int NREQ       = 3,
    parameter int STROBE_CYC = 2,
    parameter int GAP_CYC    = 2,
    parameter int LOCK_TO    = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     lock,
    input  logic [8*NREQ-1:0]   data,
    output logic [NREQ-1:0]     ack,
    output logic [NREQ-1:0]     grant,
    output logic [7:0]          uart_data,
    output logic                uart_we,
    input  logic                uart_busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
    localparam logic [7:0] GAP_LAST    = 8'(GAP_CYC - 1);
    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_TO - 1);
    localparam logic [PW-1:0] PTR_RST  = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STROBE,
        S_GAP
    } state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] ack_nxt, grant_nxt;
    logic [7:0]      data_nxt;
    logic            we_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;     // last winner; also the owner index while grant != 0
    logic [7:0]      lock_cnt, lock_cnt_nxt;
    logic [7:0]      cyc_cnt, cyc_nxt;

    logic [7:0]      byte_in [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_bytes
        assign byte_in[g] = data[8*g +: 8];
    end

    // (p + i) mod NREQ for 1 <= i <= NREQ without a divider.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return PW'(s);
    endfunction

    // Round-robin pick: scan ptr+1, ptr+2, ... so the previous winner comes last.
    logic            found;
    logic [PW-1:0]   win, cand;
    logic [NREQ-1:0] win_onehot;

    always_comb begin
        found      = 1'b0;
        win        = ptr;
        cand       = ptr;
        for (int i = 1; i <= NREQ; i++) begin
            cand = wrap_add(ptr, i);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        win_onehot      = '0;
        win_onehot[win] = 1'b1;
    end

    logic owner_locked;
    assign owner_locked = (grant != '0) && lock[ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ack       <= '0;
            grant     <= '0;
            uart_data <= '0;
            uart_we   <= 1'b0;
            ptr       <= PTR_RST;
            lock_cnt  <= '0;
            cyc_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            ack       <= ack_nxt;
            grant     <= grant_nxt;
            uart_data <= data_nxt;
            uart_we   <= we_nxt;
            ptr       <= ptr_nxt;
            lock_cnt  <= lock_cnt_nxt;
            cyc_cnt   <= cyc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ack_nxt      = '0;
        grant_nxt    = grant;
        data_nxt     = uart_data;
        we_nxt       = uart_we;
        ptr_nxt      = ptr;
        lock_cnt_nxt = '0;           // cleared unless a locked owner idles this cycle
        cyc_nxt      = cyc_cnt;

        case (state)
            S_IDLE: begin
                if (owner_locked) begin
                    if (req[ptr]) begin
                        data_nxt  = byte_in[ptr];
                        state_nxt = S_WAIT;
                    end else if (lock_cnt == LOCK_LAST) begin
                        // Owner idled too long: drop it; ptr stays so it goes last next time.
                        grant_nxt = '0;
                    end else begin
                        lock_cnt_nxt = lock_cnt + 8'd1;
                    end
                end else if (found) begin
                    grant_nxt = win_onehot;
                    ptr_nxt   = win;
                    data_nxt  = byte_in[win];
                    state_nxt = S_WAIT;
                end else begin
                    grant_nxt = '0;
                end
            end

            S_WAIT: begin
                if (!uart_busy) begin
                    we_nxt    = 1'b1;
                    cyc_nxt   = '0;
                    state_nxt = S_STROBE;
                end
            end

            S_STROBE: begin
                if (cyc_cnt == STROBE_LAST) begin
                    we_nxt    = 1'b0;
                    ack_nxt   = grant;
                    cyc_nxt   = '0;
                    state_nxt = S_GAP;
                end else begin
                    cyc_nxt = cyc_cnt + 8'd1;
                end
            end

            S_GAP: begin
                if (cyc_cnt == GAP_LAST) begin
                    cyc_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    cyc_nxt = cyc_cnt + 8'd1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter.
// Expected bytes/owners are queued as stimulus is applied and retired on each ack.
// Strobe width and inter-strobe gap are checked continuously on the port side.
module tb_uart_tx_arbiter;

    localparam int NREQ       = 3;
    localparam int STROBE_CYC = 2;
    localparam int GAP_CYC    = 2;
    localparam int LOCK_TO    = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [23:0] data;
    logic [2:0]  ack;
    logic [2:0]  grant;
    logic [7:0]  uart_data;
    logic        uart_we;
    logic        uart_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ       (NREQ),
        .STROBE_CYC (STROBE_CYC),
        .GAP_CYC    (GAP_CYC),
        .LOCK_TO    (LOCK_TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .lock       (lock),
        .data       (data),
        .ack        (ack),
        .grant      (grant),
        .uart_data  (uart_data),
        .uart_we    (uart_we),
        .uart_busy  (uart_busy)
    );

    typedef struct packed {
        logic [2:0] who;
        logic [7:0] byt;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic push_exp(input logic [2:0] who, input logic [7:0] byt);
        exp_t e;
        e.who = who;
        e.byt = byt;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input logic [2:0] m, input string tag);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if ((ack & m) != 3'b000) return;
        end
        chk(tag, 32'(0), 32'(1));
    endtask

    // Port-side monitor: strobe width, gap width, scoreboard retirement.
    int   hi_cnt = 0;
    int   lo_cnt = 0;
    logic prev_we = 1'b0;
    bit   have_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hi_cnt    = 0;
            lo_cnt    = 0;
            prev_we   = 1'b0;
            have_prev = 1'b0;
        end else begin
            if (uart_we) begin
                if (!prev_we && have_prev) chk("gap_width_ok", 32'(lo_cnt >= GAP_CYC), 32'(1));
                hi_cnt++;
            end else begin
                if (prev_we) begin
                    chk("strobe_width", 32'(hi_cnt), 32'(STROBE_CYC));
                    hi_cnt    = 0;
                    lo_cnt    = 0;
                    have_prev = 1'b1;
                end
                lo_cnt++;
            end
            prev_we = uart_we;
            if (ack != 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", 32'(ack), 32'(0));
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("ack_owner", 32'(ack), 32'(exp_e.who));
                    chk("ack_data", 32'(uart_data), 32'(exp_e.byt));
                    chk("grant_at_ack", 32'(grant), 32'(exp_e.who));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        rst_n     = 1'b0;
        req       = 3'b000;
        lock      = 3'b000;
        data      = 24'h0;
        uart_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_we", 32'(uart_we), 32'(0));
        chk("rst_data", 32'(uart_data), 32'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Round robin, all requesting: 0,1,2,0,1,2.
        data = {8'h43, 8'h42, 8'h41};
        for (int k = 0; k < 2; k++) begin
            push_exp(3'b001, 8'h41);
            push_exp(3'b010, 8'h42);
            push_exp(3'b100, 8'h43);
        end
        req = 3'b111;
        for (int k = 0; k < 6; k++) wait_ack(3'b111, "t1_ack_timeout");
        req = 3'b000;
        repeat (10) @(negedge clk);
        chk("t1_grant_idle", 32'(grant), 32'(0));

        // Port full for 50 cycles.
        uart_busy  = 1'b1;
        data[15:8] = 8'h55;
        push_exp(3'b010, 8'h55);
        req = 3'b010;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (uart_we) bad++;
        end
        chk("t2_we_held_low", 32'(bad), 32'(0));
        chk("t2_grant", 32'(grant), 32'(3'b010));
        uart_busy = 1'b0;
        @(negedge clk);
        chk("t2_strobe_next", 32'(uart_we), 32'(1));
        wait_ack(3'b010, "t2_ack_timeout");
        req = 3'b000;
        repeat (10) @(negedge clk);

        // Locked message from requester 0 while requester 2 waits.
        data[7:0] = 8'hA0;
        req  = 3'b001;
        lock = 3'b001;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (grant == 3'b001) break;
        end
        chk("t3_grant_owner0", 32'(grant), 32'(3'b001));
        data[23:16] = 8'hC2;
        req[2] = 1'b1;
        push_exp(3'b001, 8'hA0);
        push_exp(3'b001, 8'hA1);
        push_exp(3'b001, 8'hA2);
        push_exp(3'b001, 8'hA3);
        push_exp(3'b100, 8'hC2);
        for (int k = 0; k < 4; k++) begin
            wait_ack(3'b001, "t3_ack0_timeout");
            if (k < 3) begin
                data[7:0] = 8'hA1 + 8'(k);
            end else begin
                req[0]  = 1'b0;
                lock[0] = 1'b0;
            end
        end
        wait_ack(3'b100, "t3_ack2_timeout");
        req[2] = 1'b0;
        repeat (10) @(negedge clk);

        // Lock timeout: owner 0 idles with lock held, requester 1 waiting.
        data[7:0]  = 8'h11;
        data[15:8] = 8'h22;
        push_exp(3'b001, 8'h11);
        push_exp(3'b010, 8'h22);
        req  = 3'b001;
        lock = 3'b001;
        wait_ack(3'b001, "t4_ack0_timeout");
        req = 3'b010;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (grant == 3'b010) break;
        end
        chk("t4_release_not_early", 32'(n >= LOCK_TO), 32'(1));
        chk("t4_release_not_late", 32'(n <= LOCK_TO + 4), 32'(1));
        wait_ack(3'b010, "t4_ack1_timeout");
        req  = 3'b000;
        lock = 3'b000;
        repeat (10) @(negedge clk);

        // Reset in the middle of a strobe; requester 0 must win afterwards.
        data[23:16] = 8'h77;
        req = 3'b100;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (uart_we) break;
        end
        chk("t5_strobe_seen", 32'(uart_we), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_we", 32'(uart_we), 32'(0));
        chk("t5_rst_ack", 32'(ack), 32'(0));
        chk("t5_rst_grant", 32'(grant), 32'(0));
        repeat (2) @(negedge clk);
        data[7:0] = 8'h99;
        req = 3'b101;
        push_exp(3'b001, 8'h99);
        push_exp(3'b100, 8'h77);
        rst_n = 1'b1;
        wait_ack(3'b001, "t5_ack0_timeout");
        req[0] = 1'b0;
        wait_ack(3'b100, "t5_ack2_timeout");
        req[2] = 1'b0;
        repeat (10) @(negedge clk);

        // One-cycle request pulse: exactly one byte.
        data[23:16] = 8'h5A;
        push_exp(3'b100, 8'h5A);
        req = 3'b100;
        @(negedge clk);
        req = 3'b000;
        wait_ack(3'b100, "t6_ack_timeout");
        repeat (20) @(negedge clk);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'(0));
        chk("t6_grant_idle", 32'(grant), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
